// File: rtl/uart_fifo_ctrl_if.sv
// rtl/uart_fifo_ctrl_if.sv - host-side valid/ready bundle for uart_fifo_ctrl
//
// Purpose: groups the host TX-write and RX-read handshake signals.
// Signals:
//   din     host->uart  TX word
//   wr_en   host->uart  push din into the TX FIFO when wr_rdy=1
//   wr_rdy  uart->host  TX FIFO not full
//   dout    uart->host  head of RX FIFO (first-word-fall-through)
//   rd_en   host->uart  pop RX FIFO when rd_rdy=1
//   rd_rdy  uart->host  RX FIFO not empty
// Modports: master = host bus logic, slave = uart_fifo_ctrl.

interface uart_fifo_ctrl_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] din;
  logic                 wr_en;
  logic                 wr_rdy;
  logic [DATA_BITS-1:0] dout;
  logic                 rd_en;
  logic                 rd_rdy;

  modport master (
    output din, wr_en, rd_en,
    input  wr_rdy, dout, rd_rdy
  );

  modport slave (
    input  din, wr_en, rd_en,
    output wr_rdy, dout, rd_rdy
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - full-duplex UART with TX/RX FIFOs, parity and error pulses
//
// Purpose: buffered UART between host bus logic and the board serial pins.
//   Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   host        uart_fifo_ctrl_if.slave (din/wr_en/wr_rdy, dout/rd_en/rd_rdy)
//   rx          asynchronous serial input
//   tx          registered serial output, idle high
//   parity_err  1-cycle pulse, received frame had bad parity
//   frame_err   1-cycle pulse, first stop bit sampled low
//   overrun     1-cycle pulse, good frame dropped because RX FIFO full

module uart_fifo_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_fifo_ctrl_if.slave      host,
  input  logic                 rx,
  output logic                 tx,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_BREAK} rx_state_t;

  // Parity bit that completes the word: odd -> total ones odd, even -> total even.
  function automatic logic par_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]          tx_count;
  logic                 tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign host.wr_rdy = (tx_count != FULL_CNT);
  assign tx_push     = host.wr_en && host.wr_rdy;
  assign tx_head     = tx_mem[tx_rd_ptr];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= host.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (AW + 1)'(1);
        2'b01:   tx_count <= tx_count - (AW + 1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [IW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_n       = tx;
    tx_pop     = 1'b0;
    case (tx_state)
      T_IDLE: begin
        tx_n = 1'b1;
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_par_n   = par_of(tx_head);
          tx_cnt_n   = '0;
          tx_n       = 1'b0;
          tx_state_n = T_START;
        end
      end
      T_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_n       = tx_shift[0];
          tx_state_n = T_DATA;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      T_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == IDX_LAST) begin
            if (PARITY != 0) begin
              tx_n       = tx_par;
              tx_state_n = T_PARITY;
            end else begin
              tx_n       = 1'b1;
              tx_state_n = T_STOP;
            end
          end else begin
            tx_idx_n   = tx_idx + IW'(1);
            tx_shift_n = tx_shift >> 1;
            tx_n       = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      T_PARITY: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_n       = 1'b1;
          tx_state_n = T_STOP;
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      T_STOP: begin
        if (tx_cnt == STOP_LAST) begin
          tx_cnt_n = '0;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (tx_count != '0) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_par_n   = par_of(tx_head);
            tx_n       = 1'b0;
            tx_state_n = T_START;
          end else begin
            tx_n       = 1'b1;
            tx_state_n = T_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + CW'(1);
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]          rx_count;
  logic                 rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic [DATA_BITS-1:0] dout_hold;

  assign host.rd_rdy = (rx_count != '0);
  assign rx_pop      = host.rd_en && host.rd_rdy;
  // When empty, keep presenting the last word popped.
  assign host.dout   = host.rd_rdy ? rx_mem[rx_rd_ptr] : dout_hold;

  // When full, a push lands in the slot being popped in the same cycle.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      dout_hold <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + AW'(1);
        dout_hold <= rx_mem[rx_rd_ptr];
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (AW + 1)'(1);
        2'b01:   rx_count <= rx_count - (AW + 1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------- RX FSM ----------------
  logic [1:0]    rx_sync;
  logic          rx_s;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [IW-1:0] rx_idx, rx_idx_n;
  logic          rx_par_bad, rx_par_bad_n;
  logic          pe_n, fe_n, ov_n;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync    <= 2'b11;
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], rx};
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_idx     <= rx_idx_n;
      rx_shift   <= rx_shift_n;
      rx_par_bad <= rx_par_bad_n;
      parity_err <= pe_n;
      frame_err  <= fe_n;
      overrun    <= ov_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_idx_n     = rx_idx;
    rx_shift_n   = rx_shift;
    rx_par_bad_n = rx_par_bad;
    rx_push      = 1'b0;
    pe_n         = 1'b0;
    fe_n         = 1'b0;
    ov_n         = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (!rx_s) begin
          rx_cnt_n   = '0;
          rx_state_n = R_START;
        end
      end
      R_START: begin
        // Mid-start resample rejects short glitches on the line.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n = '0;
          if (rx_s) begin
            rx_state_n = R_IDLE;
          end else begin
            rx_idx_n     = '0;
            rx_par_bad_n = 1'b0;
            rx_state_n   = R_DATA;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_idx == IDX_LAST) begin
            rx_state_n = (PARITY != 0) ? R_PARITY : R_STOP;
          end else begin
            rx_idx_n = rx_idx + IW'(1);
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      R_PARITY: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n     = '0;
          rx_par_bad_n = rx_s ^ par_of(rx_shift);
          rx_state_n   = R_STOP;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          if (!rx_s) begin
            fe_n       = 1'b1;
            rx_state_n = R_BREAK;
          end else begin
            rx_state_n = R_IDLE;
            if (rx_par_bad)                          pe_n    = 1'b1;
            else if ((rx_count != FULL_CNT) || rx_pop) rx_push = 1'b1;
            else                                     ov_n    = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      R_BREAK: begin
        if (rx_s) rx_state_n = R_IDLE;
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - scoreboard bench for uart_fifo_ctrl (8N1 and 8E1 instances)

module tb_uart_fifo_ctrl;
  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam logic [2:0] E_PAR = 3'b100;
  localparam logic [2:0] E_FRM = 3'b010;
  localparam logic [2:0] E_OVR = 3'b001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_fifo_ctrl_if #(.DATA_BITS(DB)) hif_a ();
  uart_fifo_ctrl_if #(.DATA_BITS(DB)) hif_p ();

  logic tx_a, rx_a, pe_a, fe_a, ov_a, ext_a, rx_drv_a;
  logic tx_p, rx_p, pe_p, fe_p, ov_p, ext_p, rx_drv_p;

  assign rx_a = ext_a ? rx_drv_a : tx_a;
  assign rx_p = ext_p ? rx_drv_p : tx_p;

  uart_fifo_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .host(hif_a.slave), .rx(rx_a), .tx(tx_a),
    .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a)
  );

  uart_fifo_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_p (
    .clk(clk), .rst(rst), .host(hif_p.slave), .rx(rx_p), .tx(tx_p),
    .parity_err(pe_p), .frame_err(fe_p), .overrun(ov_p)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_p[$];
  logic [2:0] err_a[$];
  logic [2:0] err_p[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  // Monitor: compares each popped word and each error pulse against the scoreboard.
  always @(negedge clk) begin
    if (hif_a.rd_en && hif_a.rd_rdy) begin
      if (exp_a.size() == 0) unexpected("a_rx_word", 32'(hif_a.dout));
      else                   check("a_rx_word", 32'(hif_a.dout), 32'(exp_a.pop_front()));
    end
    if ({pe_a, fe_a, ov_a} != 3'b000) begin
      if (err_a.size() == 0) unexpected("a_err_pulse", 32'({pe_a, fe_a, ov_a}));
      else                   check("a_err_pulse", 32'({pe_a, fe_a, ov_a}), 32'(err_a.pop_front()));
    end
    if (hif_p.rd_en && hif_p.rd_rdy) begin
      if (exp_p.size() == 0) unexpected("p_rx_word", 32'(hif_p.dout));
      else                   check("p_rx_word", 32'(hif_p.dout), 32'(exp_p.pop_front()));
    end
    if ({pe_p, fe_p, ov_p} != 3'b000) begin
      if (err_p.size() == 0) unexpected("p_err_pulse", 32'({pe_p, fe_p, ov_p}));
      else                   check("p_err_pulse", 32'({pe_p, fe_p, ov_p}), 32'(err_p.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All tasks start and end at posedge+1.
  task automatic write_byte(input bit sel, input logic [7:0] b);
    if (sel) begin hif_p.din = b; hif_p.wr_en = 1'b1; end
    else     begin hif_a.din = b; hif_a.wr_en = 1'b1; end
    @(posedge clk); #1;
    hif_a.wr_en = 1'b0;
    hif_p.wr_en = 1'b0;
  endtask

  task automatic read_words(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!(sel ? hif_p.rd_rdy : hif_a.rd_rdy) && t < 300) begin
        @(posedge clk); #1;
        t++;
      end
      check(sel ? "p_rd_rdy_wait" : "a_rd_rdy_wait", 32'(sel ? hif_p.rd_rdy : hif_a.rd_rdy), 32'd1);
      if (sel) hif_p.rd_en = 1'b1; else hif_a.rd_en = 1'b1;
      @(posedge clk); #1;
      hif_a.rd_en = 1'b0;
      hif_p.rd_en = 1'b0;
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int nbits);
    if (sel) rx_drv_p = v; else rx_drv_a = v;
    repeat (nbits * CPB) @(posedge clk);
    #1;
  endtask

  // Checks tx mid-bit for nbits bits (pattern LSB = start bit); call right after the write edge.
  task automatic tx_pattern(input bit sel, input string name, input logic [15:0] pat, input int nbits);
    @(negedge clk);
    check({name, "_idle_before"}, 32'(sel ? tx_p : tx_a), 32'd1);
    @(posedge clk); @(negedge clk);
    check({name, "_start_latency"}, 32'(sel ? tx_p : tx_a), 32'd0);
    for (int k = 0; k < nbits; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("%s_bit%0d", name, k), 32'(sel ? tx_p : tx_a), 32'(pat[k]));
      repeat (3) @(posedge clk);
    end
    #1;
  endtask

  initial begin
    logic [15:0] pat;
    logic [7:0]  w;
    int          accepted;

    rst = 1'b1;
    hif_a.din = '0; hif_a.wr_en = 1'b0; hif_a.rd_en = 1'b0;
    hif_p.din = '0; hif_p.wr_en = 1'b0; hif_p.rd_en = 1'b0;
    ext_a = 1'b0; rx_drv_a = 1'b1;
    ext_p = 1'b0; rx_drv_p = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_tx", 32'(tx_a), 32'd1);
    check("reset_wr_rdy", 32'(hif_a.wr_rdy), 32'd1);
    check("reset_rd_rdy", 32'(hif_a.rd_rdy), 32'd0);
    check("reset_dout", 32'(hif_a.dout), 32'd0);
    check("reset_errs", 32'({pe_a, fe_a, ov_a}), 32'd0);
    @(posedge clk); #1;

    // 1: 8N1 0xA5 waveform: start, 1,0,1,0,0,1,0,1, stop
    write_byte(1'b0, 8'hA5);
    exp_a.push_back(8'hA5);
    pat = 16'b000000_1101001010;
    tx_pattern(1'b0, "t1_tx", pat, 10);
    read_words(1'b0, 1);

    // 2: fill TX FIFO until wr_rdy drops; 17th received frame overruns
    repeat (10) @(posedge clk); #1;
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      if (!hif_a.wr_rdy) break;
      hif_a.din = 8'(i); hif_a.wr_en = 1'b1;
      @(posedge clk); #1;
      accepted++;
    end
    hif_a.wr_en = 1'b0;
    check("t2_writes_accepted", 32'(accepted), 32'd17);
    for (int i = 0; i < 16; i++) exp_a.push_back(8'(i));
    err_a.push_back(E_OVR);
    repeat (720) @(posedge clk); #1;
    check("t2_rd_rdy_full", 32'(hif_a.rd_rdy), 32'd1);
    read_words(1'b0, 16);
    check("t2_rd_rdy_drained", 32'(hif_a.rd_rdy), 32'd0);
    check("t2_dout_hold", 32'(hif_a.dout), 32'h0F);

    // 3: even parity on dut_p: 0x07 has parity bit 1; then an inverted parity frame
    write_byte(1'b1, 8'h07);
    exp_p.push_back(8'h07);
    pat = 16'b00000_11000001110;
    tx_pattern(1'b1, "t3_tx", pat, 11);
    read_words(1'b1, 1);
    repeat (10) @(posedge clk); #1;
    ext_p = 1'b1;
    err_p.push_back(E_PAR);
    w = 8'h07;
    drive_bit(1'b1, 1'b0, 1);
    for (int k = 0; k < 8; k++) drive_bit(1'b1, w[k], 1);
    drive_bit(1'b1, 1'b0, 1);
    drive_bit(1'b1, 1'b1, 3);
    check("t3_rd_rdy_after_perr", 32'(hif_p.rd_rdy), 32'd0);
    ext_p = 1'b0;

    // 4: frame with stop=0 -> frame_err; then a 1-cycle glitch -> nothing
    ext_a = 1'b1;
    err_a.push_back(E_FRM);
    w = 8'h55;
    drive_bit(1'b0, 1'b0, 1);
    for (int k = 0; k < 8; k++) drive_bit(1'b0, w[k], 1);
    drive_bit(1'b0, 1'b0, 3);
    drive_bit(1'b0, 1'b1, 3);
    check("t4_rd_rdy_after_ferr", 32'(hif_a.rd_rdy), 32'd0);
    rx_drv_a = 1'b0;
    @(posedge clk); #1;
    rx_drv_a = 1'b1;
    repeat (60) @(posedge clk); #1;
    check("t4_rd_rdy_after_glitch", 32'(hif_a.rd_rdy), 32'd0);
    ext_a = 1'b0;

    // 5: full RX FIFO, rd_en coincident with the 17th stop sample -> no overrun
    for (int i = 0; i < 16; i++) begin
      write_byte(1'b0, 8'(8'h20 + i));
      exp_a.push_back(8'(8'h20 + i));
    end
    repeat (700) @(posedge clk); #1;
    check("t5_rd_rdy_full", 32'(hif_a.rd_rdy), 32'd1);
    write_byte(1'b0, 8'h30);
    exp_a.push_back(8'h30);
    // write edge N: tx start at N+1, stop sample at N+42
    repeat (41) @(posedge clk); #1;
    hif_a.rd_en = 1'b1;
    @(posedge clk); #1;
    hif_a.rd_en = 1'b0;
    check("t5_rd_rdy_after", 32'(hif_a.rd_rdy), 32'd1);
    repeat (5) @(posedge clk); #1;
    read_words(1'b0, 16);
    check("t5_rd_rdy_drained", 32'(hif_a.rd_rdy), 32'd0);

    // 6: reset mid TX data bit and mid RX frame
    write_byte(1'b0, 8'h81);
    write_byte(1'b0, 8'h82);
    write_byte(1'b0, 8'h83);
    repeat (57) @(posedge clk); #1;
    check("t6_pre_rd_rdy", 32'(hif_a.rd_rdy), 32'd1);
    check("t6_pre_tx", 32'(tx_a), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_tx", 32'(tx_a), 32'd1);
    check("t6_wr_rdy", 32'(hif_a.wr_rdy), 32'd1);
    check("t6_rd_rdy", 32'(hif_a.rd_rdy), 32'd0);
    check("t6_dout", 32'(hif_a.dout), 32'd0);
    @(posedge clk); #1;
    write_byte(1'b0, 8'h3C);
    exp_a.push_back(8'h3C);
    read_words(1'b0, 1);
    repeat (100) @(posedge clk); #1;
    check("t6_no_leftover", 32'(hif_a.rd_rdy), 32'd0);

    repeat (5) @(posedge clk); #1;
    check("end_exp_a_empty", 32'(exp_a.size()), 32'd0);
    check("end_exp_p_empty", 32'(exp_p.size()), 32'd0);
    check("end_err_a_empty", 32'(err_a.size()), 32'd0);
    check("end_err_p_empty", 32'(err_p.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
